// File: rtl/pair_invariant_monitor_if.sv
// rtl/pair_invariant_monitor_if.sv - control, operand and result bundle for pair_invariant_monitor
interface pair_invariant_monitor_if #(
    parameter int NCH   = 10,
    parameter int CNT_W = 8,
    parameter int TS_W  = 16
);
    localparam int CH_W = $clog2(NCH + 1);

    logic               en;
    logic               clr;
    logic [NCH-1:0]     mask;
    logic [NCH:0]       foo;
    logic [NCH:0]       bar;

    logic [1:0]         state;
    logic [NCH:0]       fail_sticky;
    logic               first_vld;
    logic [CH_W-1:0]    first_ch;
    logic [TS_W-1:0]    first_time;
    logic [CNT_W-1:0]   fail_cnt;
    logic               irq;

    modport master (
        output en, clr, mask, foo, bar,
        input  state, fail_sticky, first_vld, first_ch, first_time, fail_cnt, irq
    );

    modport slave (
        input  en, clr, mask, foo, bar,
        output state, fail_sticky, first_vld, first_ch, first_time, fail_cnt, irq
    );
endinterface

// File: rtl/pair_invariant_monitor.sv
// rtl/pair_invariant_monitor.sv - per-channel foo/bar invariant checker with settle, sticky flags and first-fail capture
module pair_invariant_monitor #(
    parameter int NCH        = 10,
    parameter int MODE       = 0,
    parameter int FAIL_LEN   = 1,
    parameter int SETTLE_CYC = 4,
    parameter int CNT_W      = 8,
    parameter int TS_W       = 16
) (
    input  logic clk,
    input  logic rst_n,
    pair_invariant_monitor_if.slave bus
);
    localparam int NP    = NCH + 1;
    localparam int CH_W  = $clog2(NCH + 1);
    localparam int RUN_W = 8;
    localparam logic [RUN_W-1:0] FL     = RUN_W'(FAIL_LEN);
    localparam logic [RUN_W-1:0] FL_M1  = RUN_W'(FAIL_LEN - 1);
    localparam logic [7:0]       SETTLE = 8'(SETTLE_CYC);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_ARMED  = 2'd2
    } state_t;

    state_t                       state_q;
    logic [7:0]                   settle_q;
    logic [NP-1:0][RUN_W-1:0]     run_q;
    logic [TS_W-1:0]              ts_q;
    logic [NP-1:0]                sticky_q;
    logic                         first_vld_q;
    logic [CH_W-1:0]              first_ch_q;
    logic [TS_W-1:0]              first_time_q;
    logic [CNT_W-1:0]             fail_cnt_q;
    logic                         irq_q;

    logic [NP-1:0]                pair_fail;
    logic [NP-1:0]                evt;
    logic [NP-1:0][RUN_W-1:0]     run_nxt;
    logic                         any_evt;
    logic [CH_W-1:0]              evt_ch;

    // Operator applied to one pair; a 1 means the invariant holds.
    function automatic logic pair_pass(input logic f, input logic b);
        case (MODE)
            0:       return f && b;
            1:       return f == b;
            default: return !f || b;
        endcase
    endfunction

    // Per-pair failure, run-length update and violation-event detection.
    always_comb begin
        pair_fail = '0;
        evt       = '0;
        run_nxt   = '0;
        for (int i = 0; i < NP; i++) begin
            if (i < NCH) begin
                pair_fail[i] = !bus.mask[i] && !pair_pass(bus.foo[i], bus.bar[i]);
            end else begin
                pair_fail[i] = !pair_pass(bus.foo[i], bus.bar[i]);
            end
            if (!pair_fail[i]) begin
                run_nxt[i] = '0;
            end else if (run_q[i] >= FL) begin
                run_nxt[i] = FL;
            end else begin
                run_nxt[i] = run_q[i] + 1'b1;
            end
            // Event only on the step into FAIL_LEN; a saturated run cannot re-fire.
            evt[i] = pair_fail[i] && (run_q[i] == FL_M1);
        end
    end

    // Lowest-index pair among this edge's events (global pair is index NCH).
    always_comb begin
        any_evt = |evt;
        evt_ch  = '0;
        for (int i = NP - 1; i >= 0; i--) begin
            if (evt[i]) begin
                evt_ch = CH_W'(i);
            end
        end
    end

    // Monitor FSM with run counters, timestamp and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            settle_q     <= '0;
            run_q        <= '0;
            ts_q         <= '0;
            sticky_q     <= '0;
            first_vld_q  <= 1'b0;
            first_ch_q   <= '0;
            first_time_q <= '0;
            fail_cnt_q   <= '0;
            irq_q        <= 1'b0;
        end else if (bus.clr) begin
            // Clear beats any event on the same edge; enable decides where we restart.
            run_q        <= '0;
            ts_q         <= '0;
            sticky_q     <= '0;
            first_vld_q  <= 1'b0;
            first_ch_q   <= '0;
            first_time_q <= '0;
            fail_cnt_q   <= '0;
            irq_q        <= 1'b0;
            if (!bus.en) begin
                state_q  <= S_IDLE;
                settle_q <= '0;
            end else if (SETTLE_CYC == 0) begin
                state_q  <= S_ARMED;
                settle_q <= '0;
            end else begin
                state_q  <= S_SETTLE;
                settle_q <= SETTLE;
            end
        end else if (!bus.en) begin
            // Disable drops run state but keeps the recorded results.
            state_q  <= S_IDLE;
            settle_q <= '0;
            run_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (SETTLE_CYC == 0) begin
                        state_q <= S_ARMED;
                        ts_q    <= '0;
                    end else begin
                        state_q  <= S_SETTLE;
                        settle_q <= SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_q <= 8'd1) begin
                        state_q  <= S_ARMED;
                        settle_q <= '0;
                        ts_q     <= '0;
                    end else begin
                        settle_q <= settle_q - 8'd1;
                    end
                end
                S_ARMED: begin
                    run_q    <= run_nxt;
                    sticky_q <= sticky_q | evt;
                    if (ts_q != '1) begin
                        ts_q <= ts_q + 1'b1;
                    end
                    if (any_evt) begin
                        if (fail_cnt_q != '1) begin
                            fail_cnt_q <= fail_cnt_q + 1'b1;
                        end
                        if (!first_vld_q) begin
                            first_vld_q  <= 1'b1;
                            first_ch_q   <= evt_ch;
                            first_time_q <= ts_q;
                            irq_q        <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    settle_q <= '0;
                    run_q    <= '0;
                end
            endcase
        end
    end

    assign bus.state       = state_q;
    assign bus.fail_sticky = sticky_q;
    assign bus.first_vld   = first_vld_q;
    assign bus.first_ch    = first_ch_q;
    assign bus.first_time  = first_time_q;
    assign bus.fail_cnt    = fail_cnt_q;
    assign bus.irq         = irq_q;
endmodule
